// File: rtl/connect8_pkg.sv
// Shared constants, FSM state type and shape-measuring helpers for the CONNECT8 board logic.
// Shapes are 8x8 bitmaps: bit r*8+c is row r, column c, anchored at bit 0.
package connect8_pkg;

  localparam int BOARD_DIM = 8;
  localparam int CELL_PTS  = 1;
  localparam int LINE_PTS  = 10;

  typedef enum logic [3:0] {
    INIT,
    IDLE,
    CHECK,
    COMMIT,
    CLEAR,
    REFILL,
    REFILL_WAIT,
    SCAN,
    OVER
  } state_t;

  // Width is one past the right-most occupied column over all rows; 0 for an empty shape.
  function automatic logic [3:0] shape_width(input logic [63:0] shape);
    logic [7:0] cols;
    logic [3:0] w;
    cols = '0;
    for (int r = 0; r < BOARD_DIM; r++) cols = cols | shape[r*8 +: 8];
    w = '0;
    for (int c = 0; c < BOARD_DIM; c++) if (cols[c]) w = 4'(c + 1);
    return w;
  endfunction

  function automatic logic [3:0] shape_height(input logic [63:0] shape);
    logic [3:0] h;
    h = '0;
    for (int r = 0; r < BOARD_DIM; r++) if (shape[r*8 +: 8] != 8'h00) h = 4'(r + 1);
    return h;
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] shape);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) cnt = cnt + 7'(shape[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/fit_checker.sv
// Combinational test of whether a shape anchored at (row, col) stays on the board
// and lands only on empty cells.
module fit_checker
  import connect8_pkg::*;
(
  input  logic [63:0] shape,
  input  logic [2:0]  row,
  input  logic [2:0]  col,
  input  logic [63:0] board,
  output logic        fits
);

  logic [4:0]  col_end;
  logic [4:0]  row_end;
  logic [63:0] placed;

  always_comb begin
    col_end = {2'b00, col} + {1'b0, shape_width(shape)};
    row_end = {2'b00, row} + {1'b0, shape_height(shape)};
    placed  = shape << {row, col};
    fits    = (shape != '0) && (col_end <= 5'd8) && (row_end <= 5'd8) &&
              ((placed & board) == '0);
  end

endmodule

// File: rtl/block_placer.sv
// Applies player placements to the 8x8 board: legality check, commit, row/column clear,
// scoring, refill requests and an exhaustive game-over scan.
module block_placer
  import connect8_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] block1,
  input  logic [63:0] block2,
  input  logic [63:0] block3,
  input  logic        place_req,
  input  logic [1:0]  sel,
  input  logic [2:0]  row,
  input  logic [2:0]  col,
  output logic        busy,
  output logic        place_done,
  output logic        place_ok,
  output logic [63:0] board,
  output logic [2:0]  slot_used,
  output logic [4:0]  lines_cleared,
  output logic [15:0] score,
  output logic        generate_new,
  output logic        game_over
);

  state_t      state;
  logic [1:0]  sel_q;
  logic [2:0]  row_q;
  logic [2:0]  col_q;
  logic [1:0]  scan_slot;
  logic [5:0]  scan_pos;
  logic [6:0]  cell_pts;

  logic [63:0] sel_shape;
  logic        sel_free;
  logic [2:0]  sel_onehot;
  logic [63:0] placed;
  logic [2:0]  eligible;
  logic        scan_found;
  logic [1:0]  scan_cur;
  logic [63:0] scan_shape;
  logic [63:0] fc_shape;
  logic [2:0]  fc_row;
  logic [2:0]  fc_col;
  logic        fits;
  logic [7:0]  full_rows;
  logic [7:0]  full_cols;
  logic [63:0] clear_mask;
  logic [4:0]  line_count;
  logic [16:0] score_sum;
  logic [15:0] score_next;

  assign busy = (state != IDLE);

  // Slot index 3 decodes to an empty, never-free slot so it always fails the legality test.
  always_comb begin
    sel_shape  = '0;
    sel_free   = 1'b0;
    sel_onehot = 3'b000;
    case (sel_q)
      2'd0: begin sel_shape = block1; sel_free = !slot_used[0]; sel_onehot = 3'b001; end
      2'd1: begin sel_shape = block2; sel_free = !slot_used[1]; sel_onehot = 3'b010; end
      2'd2: begin sel_shape = block3; sel_free = !slot_used[2]; sel_onehot = 3'b100; end
      default: ;
    endcase
    placed = sel_shape << {row_q, col_q};
  end

  // The scan jumps straight to the lowest usable slot at or after scan_slot.
  always_comb begin
    eligible[0] = !slot_used[0] && (block1 != '0);
    eligible[1] = !slot_used[1] && (block2 != '0);
    eligible[2] = !slot_used[2] && (block3 != '0);
    scan_found  = 1'b0;
    scan_cur    = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (eligible[i] && (2'(i) >= scan_slot)) begin
        scan_found = 1'b1;
        scan_cur   = 2'(i);
      end
    end
    case (scan_cur)
      2'd0:    scan_shape = block1;
      2'd1:    scan_shape = block2;
      default: scan_shape = block3;
    endcase
  end

  always_comb begin
    if (state == SCAN) begin
      fc_shape = scan_shape;
      fc_row   = scan_pos[5:3];
      fc_col   = scan_pos[2:0];
    end else begin
      fc_shape = sel_shape;
      fc_row   = row_q;
      fc_col   = col_q;
    end
  end

  fit_checker u_fit (
    .shape (fc_shape),
    .row   (fc_row),
    .col   (fc_col),
    .board (board),
    .fits  (fits)
  );

  // Full rows and columns are cleared as one union so intersections are counted once as cells.
  always_comb begin
    full_rows  = '0;
    full_cols  = '1;
    clear_mask = '0;
    line_count = '0;
    for (int r = 0; r < BOARD_DIM; r++) begin
      full_rows[r] = &board[r*8 +: 8];
      for (int c = 0; c < BOARD_DIM; c++) full_cols[c] = full_cols[c] & board[r*8 + c];
    end
    for (int r = 0; r < BOARD_DIM; r++)
      for (int c = 0; c < BOARD_DIM; c++)
        if (full_rows[r] || full_cols[c]) clear_mask[r*8 + c] = 1'b1;
    for (int i = 0; i < BOARD_DIM; i++)
      line_count = line_count + 5'(full_rows[i]) + 5'(full_cols[i]);
    score_sum  = {1'b0, score} + 17'(cell_pts) * 17'(CELL_PTS) + 17'(line_count) * 17'(LINE_PTS);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= INIT;
      sel_q         <= '0;
      row_q         <= '0;
      col_q         <= '0;
      scan_slot     <= '0;
      scan_pos      <= '0;
      cell_pts      <= '0;
      board         <= '0;
      slot_used     <= '0;
      lines_cleared <= '0;
      score         <= '0;
      place_done    <= 1'b0;
      place_ok      <= 1'b0;
      generate_new  <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      place_done   <= 1'b0;
      generate_new <= 1'b0;
      case (state)
        INIT: begin
          generate_new <= 1'b1;
          state        <= REFILL_WAIT;
        end
        IDLE: begin
          if (place_req) begin
            sel_q <= sel;
            row_q <= row;
            col_q <= col;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (sel_free && fits) begin
            state <= COMMIT;
          end else begin
            place_done <= 1'b1;
            place_ok   <= 1'b0;
            state      <= IDLE;
          end
        end
        COMMIT: begin
          board     <= board | placed;
          slot_used <= slot_used | sel_onehot;
          cell_pts  <= popcount64(sel_shape);
          state     <= CLEAR;
        end
        CLEAR: begin
          board         <= board & ~clear_mask;
          lines_cleared <= line_count;
          score         <= score_next;
          place_done    <= 1'b1;
          place_ok      <= 1'b1;
          scan_slot     <= '0;
          scan_pos      <= '0;
          state         <= (slot_used == 3'b111) ? REFILL : SCAN;
        end
        REFILL: begin
          generate_new <= 1'b1;
          slot_used    <= '0;
          state        <= REFILL_WAIT;
        end
        REFILL_WAIT: begin
          scan_slot <= '0;
          scan_pos  <= '0;
          state     <= SCAN;
        end
        SCAN: begin
          if (!scan_found) begin
            game_over <= 1'b1;
            state     <= OVER;
          end else if (fits) begin
            state <= IDLE;
          end else if (scan_pos == 6'd63) begin
            scan_slot <= scan_cur + 2'd1;
            scan_pos  <= '0;
          end else begin
            scan_slot <= scan_cur;
            scan_pos  <= scan_pos + 6'd1;
          end
        end
        OVER: game_over <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_block_placer.sv
// Randomised scoreboard bench for block_placer; a grid-of-cells model predicts every
// place_done response, the board after each scan and the game-over flag.
module tb_block_placer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] block1 = '0;
  logic [63:0] block2 = '0;
  logic [63:0] block3 = '0;
  logic        place_req = 1'b0;
  logic [1:0]  sel = '0;
  logic [2:0]  row = '0;
  logic [2:0]  col = '0;
  logic        busy;
  logic        place_done;
  logic        place_ok;
  logic [63:0] board;
  logic [2:0]  slot_used;
  logic [4:0]  lines_cleared;
  logic [15:0] score;
  logic        generate_new;
  logic        game_over;

  always #5 clk = ~clk;

  block_placer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .block1        (block1),
    .block2        (block2),
    .block3        (block3),
    .place_req     (place_req),
    .sel           (sel),
    .row           (row),
    .col           (col),
    .busy          (busy),
    .place_done    (place_done),
    .place_ok      (place_ok),
    .board         (board),
    .slot_used     (slot_used),
    .lines_cleared (lines_cleared),
    .score         (score),
    .generate_new  (generate_new),
    .game_over     (game_over)
  );

  typedef struct {
    bit          ok;
    logic [63:0] board;
    logic [15:0] score;
    logic [2:0]  slots;
    logic [4:0]  lines;
  } exp_t;

  localparam int NSETS = 256;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] set_tab [NSETS][3];
  logic [63:0] lib [10] = '{64'h1, 64'h3, 64'h101, 64'h7, 64'h10101, 64'h303,
                            64'h1F, 64'h103, 64'h70707, 64'h0};
  int          gen_idx = 0;
  int          gen_pulses = 0;
  bit          gen_prev = 1'b0;

  bit          grid [8][8];
  logic [63:0] m_blocks [3];
  bit          m_used [3];
  int          m_score = 0;
  int          m_set_idx = -1;
  bit          m_over = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endfunction

  function automatic logic [63:0] m_board_bits();
    logic [63:0] b;
    b = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r*8 + c] = grid[r][c];
    return b;
  endfunction

  function automatic logic [2:0] m_used_bits();
    return {m_used[2], m_used[1], m_used[0]};
  endfunction

  // A shape fits when each of its cells lands on an existing, empty board cell.
  function automatic bit m_fits(input logic [63:0] shape, input int r0, input int c0);
    if (shape == '0) return 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (shape[r*8 + c]) begin
          if (r0 + r > 7 || c0 + c > 7) return 1'b0;
          if (grid[r0 + r][c0 + c]) return 1'b0;
        end
    return 1'b1;
  endfunction

  function automatic bit m_any_fit();
    for (int s = 0; s < 3; s++)
      if (!m_used[s] && m_blocks[s] != '0)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++)
            if (m_fits(m_blocks[s], r, c)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_load_next_set();
    m_set_idx++;
    for (int s = 0; s < 3; s++) begin
      m_blocks[s] = set_tab[m_set_idx % NSETS][s];
      m_used[s]   = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) grid[r][c] = 1'b0;
    m_score = 0;
    m_load_next_set();
    m_over = !m_any_fit();
  endfunction

  function automatic exp_t model_request(input int s, input int r0, input int c0);
    exp_t e;
    int   cells;
    int   lines;
    bit   full_r [8];
    bit   full_c [8];
    e.ok    = 1'b0;
    e.lines = '0;
    if (s != 3 && !m_used[s] && m_fits(m_blocks[s], r0, c0)) begin
      e.ok  = 1'b1;
      cells = 0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (m_blocks[s][r*8 + c]) begin
            grid[r0 + r][c0 + c] = 1'b1;
            cells++;
          end
      m_used[s] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        full_r[i] = 1'b1;
        full_c[i] = 1'b1;
      end
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (!grid[r][c]) begin
            full_r[r] = 1'b0;
            full_c[c] = 1'b0;
          end
      lines = 0;
      for (int i = 0; i < 8; i++) lines += int'(full_r[i]) + int'(full_c[i]);
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          if (full_r[r] || full_c[c]) grid[r][c] = 1'b0;
      m_score = m_score + cells + 10 * lines;
      if (m_score > 65535) m_score = 65535;
      e.lines = 5'(lines);
    end
    e.board = m_board_bits();
    e.score = 16'(m_score);
    e.slots = m_used_bits();
    if (e.ok) begin
      if (m_used[0] && m_used[1] && m_used[2]) m_load_next_set();
      m_over = !m_any_fit();
    end
    return e;
  endfunction

  // Monitor: every place_done pulse consumes exactly one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && place_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_place_done: got 1, expected 0");
      end else begin
        e = exp_q.pop_front();
        check("place_ok", 64'(place_ok), 64'(e.ok));
        check("done_board", board, e.board);
        check("done_score", 64'(score), 64'(e.score));
        check("done_slot_used", 64'(slot_used), 64'(e.slots));
        if (e.ok) check("lines_cleared", 64'(lines_cleared), 64'(e.lines));
      end
    end
  end

  // Block generator stand-in: hands out the next prepared set on each generate_new pulse.
  always @(negedge clk) begin
    if (reset_n && gen_prev) check("gen_pulse_width", 64'(generate_new), 64'd0);
    if (reset_n && generate_new && !gen_prev) begin
      block1 = set_tab[gen_idx % NSETS][0];
      block2 = set_tab[gen_idx % NSETS][1];
      block3 = set_tab[gen_idx % NSETS][2];
      gen_idx++;
      gen_pulses++;
    end
    gen_prev = reset_n && generate_new;
  end

  task automatic build_sets();
    set_tab[0] = '{64'h301, 64'h303, 64'h7};
    set_tab[1] = '{64'h1F, 64'h1, 64'h1};
    set_tab[2] = '{64'h7F, 64'h0001010101010101, 64'h1};
    for (int i = 3; i <= 12; i++) set_tab[i] = '{64'h1, 64'h1, 64'h1};
    set_tab[13] = '{64'h1, 64'h1, 64'h303};
    for (int i = 14; i < NSETS; i++)
      for (int s = 0; s < 3; s++) set_tab[i][s] = lib[$urandom_range(0, 9)];
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL place_done_timeout: got none after %0d cycles, expected a pulse", bound);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && !game_over && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy && !game_over) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", bound);
    end
  endtask

  task automatic applyStimulus(input int s, input int r, input int c);
    exp_q.push_back(model_request(s, r, c));
    place_req = 1'b1;
    sel       = 2'(s);
    row       = 3'(r);
    col       = 3'(c);
    @(negedge clk);
    #1;
    place_req = 1'b0;
    wait_done(20);
  endtask

  task automatic checkOutput();
    check("busy", 64'(busy), 64'(m_over));
    check("game_over", 64'(game_over), 64'(m_over));
    check("board", board, m_board_bits());
    check("slot_used", 64'(slot_used), 64'(m_used_bits()));
    check("score", 64'(score), 64'(m_score));
  endtask

  task automatic checkReset();
    check("rst_board", board, 64'd0);
    check("rst_slot_used", 64'(slot_used), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_lines", 64'(lines_cleared), 64'd0);
    check("rst_place_done", 64'(place_done), 64'd0);
    check("rst_place_ok", 64'(place_ok), 64'd0);
    check("rst_generate_new", 64'(generate_new), 64'd0);
    check("rst_game_over", 64'(game_over), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
  endtask

  task automatic place(input int s, input int r, input int c);
    applyStimulus(s, r, c);
    wait_idle(400);
    checkOutput();
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    wait_idle(400);
    checkOutput();
  endtask

  initial begin
    int k;
    int s;
    int cand[$];
    build_sets();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 checkReset();
    repeat (2) @(negedge clk);
    release_reset();

    // First set: basic placement, out of bounds, bad slot, collision, reuse, refill.
    place(0, 0, 0);
    check("basic_board", board, 64'h301);
    check("basic_score", 64'(score), 64'd3);
    place(2, 0, 6);
    place(3, 0, 0);
    place(1, 0, 0);
    place(0, 3, 3);
    place(1, 2, 0);
    place(2, 4, 0);

    // Second set: wide shape off the right edge, then an async reset while scanning.
    place(0, 0, 4);
    applyStimulus(1, 7, 7);
    #1 reset_n = 1'b0;
    #1 checkReset();
    release_reset();

    // Row 0 and column 7 complete together on the last cell.
    place(0, 0, 0);
    place(1, 1, 7);
    place(2, 0, 7);
    check("cross_lines", 64'(lines_cleared), 64'd2);
    check("cross_score", 64'(score), 64'd35);
    check("cross_board", board, 64'd0);

    // Build a checkerboard with single cells; the leftover 2x2 can never fit.
    k = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if ((r + c) % 2 == 0) begin
          place(k % 3, r, c);
          k++;
        end
    check("checker_board", board, 64'hAA55AA55AA55AA55);
    check("checker_over", 64'(game_over), 64'd1);

    place_req = 1'b1;
    sel       = 2'd2;
    row       = 3'd0;
    col       = 3'd1;
    @(negedge clk);
    #1 place_req = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checkOutput();

    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    release_reset();

    // Random play, restarting whenever the model predicts the game has ended.
    for (int i = 0; i < 150; i++) begin
      if (m_over) begin
        @(negedge clk);
        reset_n = 1'b0;
        #1 checkReset();
        release_reset();
      end
      cand.delete();
      for (int j = 0; j < 3; j++) if (!m_used[j]) cand.push_back(j);
      if (cand.size() > 0 && $urandom_range(0, 9) < 8)
        s = cand[$urandom_range(0, cand.size() - 1)];
      else
        s = $urandom_range(0, 3);
      place(s, $urandom_range(0, 7), $urandom_range(0, 7));
    end

    check("gen_pulse_count", 64'(gen_pulses), 64'(m_set_idx + 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_placer.md
# block_placer

Consumes the three shapes from the block generator and applies player placements to the 8x8 CONNECT8 board. It checks legality, commits the shape, clears full rows and columns, and keeps score. It requests a new set once all three shapes are used, and detects game over by scanning every remaining shape against every board position. It sits between the input/cursor logic and the VGA renderer, which reads `board`.

## Interface
- No parameters; board geometry is fixed at 8x8.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `block1`, `block2`, `block3` in 64 each: shapes from the generator. Bit index is r*8+c, with row 0 in the low byte and col 0 in bit 0. Shapes are anchored at the top-left (bit 0 row/col occupied). A value of 0 means the slot is empty.
- `place_req` in 1: request pulse; sampled only in IDLE.
- `sel` in 2: slot 0..2; a value of 3 is always illegal.
- `row`, `col` in 3 each: target cell for the shape's anchor.
- `busy` out 1: high in every state except IDLE.
- `place_done` out 1: one-cycle pulse ending each accepted request.
- `place_ok` out 1: result of the last request; valid while `place_done` is high and held after.
- `board` out 64: occupancy.
- `slot_used` out 3: one bit per slot, set once that slot is placed.
- `lines_cleared` out 5: rows plus columns cleared by the last placement (0..16).
- `score` out 16: saturating.
- `generate_new` out 1: one-cycle pulse to the generator.
- `game_over` out 1: sticky until reset.

## Operation
- **States:** INIT, IDLE, CHECK, COMMIT, CLEAR, REFILL, REFILL_WAIT, SCAN, OVER.
- **Reset values:** state=INIT. `board`, `slot_used`, `score`, `lines_cleared` are 0. `place_done`, `place_ok`, `generate_new`, `game_over` are 0. `busy`=1.
- **INIT:** pulse `generate_new` and go to REFILL_WAIT. REFILL_WAIT always lasts one cycle so the generator's registers settle, then goes to SCAN.
- **IDLE:** on `place_req`, register `sel`, `row`, `col` and go to CHECK. When not in IDLE, `place_req` is ignored and never queued.
- **CHECK:** the shape S = block[sel]. Compute width w = (highest set column of the OR of all bytes) + 1. Compute height h = (highest nonzero byte) + 1. The shifted shape is P = S << (row*8+col).
  - The placement is legal iff all hold: sel≠3, slot unused, S≠0, col+w≤8, row+h≤8, and (P & board)==0.
  - If illegal: `place_done`=1, `place_ok`=0, go to IDLE; the board is untouched.
  - If legal: go to COMMIT.
- **COMMIT:** `board |= P`, set `slot_used[sel]`, capture popcount(S) into the score adder, go to CLEAR.
- **CLEAR:** find full rows (byte==FF) and full columns (bit c set in all 8 bytes) on the committed board.
  - Clear the union of those cells in one step, so a cell at a row/column intersection is cleared once.
  - `lines_cleared` = number of rows + columns.
  - `score += popcount(S) + 10*lines_cleared`, saturating at FFFF.
  - `place_done`=1, `place_ok`=1.
  - Next state: REFILL if `slot_used`==111, else SCAN.
- **REFILL:** `generate_new`=1, `slot_used` becomes 000, go to REFILL_WAIT.
- **SCAN:** test one (slot, pos) pair per cycle, pos 0..63 per slot, slots 0 to 2.
  - Skip used or zero slots in zero cycles.
  - Apply the same fit rule as CHECK.
  - On the first fit, go to IDLE.
  - If all pairs are exhausted without a fit, go to OVER. This includes the case where every slot is empty or used.
- **OVER:** `game_over`=1 and `busy`=1; stay until reset.

## Timing
- Let `place_req` be sampled at edge N.
  - Illegal request: `place_done`/`place_ok` are registered at N+1.
  - Legal request: the board is updated at N+2, the cleared board, score and `place_done` at N+3.
- The scan then adds 1 to 192 cycles before `busy` falls.
- `generate_new` is high for exactly one cycle. The new blocks are read no earlier than two edges later.
- Asserting `reset_n` low mid-operation aborts immediately and restores the reset values. Any partial commit is discarded.

## Structure
- The package `connect8_pkg` holds:
  - `BOARD_DIM`=8
  - `CELL_PTS`=1, `LINE_PTS`=10
  - the state enum
  - functions `shape_width`, `shape_height`, `popcount64`
- Sub-module `fit_checker` is combinational: inputs shape, row, col, board; output fits.
  - One instance only, shared between CHECK and SCAN through a mux on its inputs.

## Test plan
- **Basic placement:** blocks 0x301/0x303/0x7; after the reset refill, place sel=0 (0,0) → board=0x301, `place_ok`=1, score=3, `slot_used`=001.
- **Out of bounds:** block 0x1F at row 0, col 4 → `place_ok`=0, board and score unchanged, `slot_used` unchanged. Then sel=3 → rejected.
- **Collision and reuse:** 0x303 at (0,0) over board 0x301 → rejected. Re-placing a used slot → rejected.
- **Simultaneous row and column clear:**
  - Pre-fill by legal placements until row 0 is 7 cells (cols 0..6) and col 7 holds rows 1..7.
  - Place 1x1 at (0,7) → row 0 and col 7 are both cleared, `lines_cleared`=2, score += 1+20, and (0,7) is cleared.
- **Refill:** the third legal placement → `generate_new` is high for exactly 1 cycle, `slot_used` goes to 000, and the scan uses the new blocks.
- **Game over and reset:**
  - Checkerboard board (0xAA55…) with remaining shape 0x303 → after 64 scan cycles, `game_over`=1. Further `place_req` is ignored.
  - Asserting `reset_n` low mid-SCAN → all outputs return to their reset values asynchronously.
